zbt_pixel_packer: RTL

Producer-side front end for ZBT frame storage. Accepts a stream of 9-bit camera pixels, packs four per 36-bit ZBT word, and assigns each word a linear frame address. Words are queued in a 4-entry FIFO and issued one per write slot granted by the ZBT timing logic. It fills the frame buffer that downstream per-pixel ZBT read/processing stages consume.

---
 rtl/zbt_pixel_packer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/zbt_pixel_packer.sv
// zbt_pixel_packer: packs 9-bit camera pixels four per 36-bit ZBT word,
// tags each word with a linear frame address and queues it for write slots.
module zbt_pixel_packer #(
    parameter int          WIDTH     = 720,
    parameter int          HEIGHT    = 480,
    parameter logic [18:0] BASE_ADDR = 19'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_valid,
    input  logic [8:0]  pix_data,
    input  logic        pix_sof,
    input  logic        wr_slot,
    output logic        zbt_we,
    output logic [18:0] zbt_write_addr,
    output logic [35:0] zbt_write_data,
    output logic [2:0]  fifo_level,
    output logic        overflow,
    output logic        frame_done
);

    localparam int          WORDS     = WIDTH * HEIGHT / 4;
    localparam logic [18:0] LAST_ADDR = BASE_ADDR + 19'(WORDS - 1);

    logic [1:0]  r_lane;
    logic [35:0] r_word;
    logic [18:0] r_addr;

    logic [54:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_level;
    logic        r_ovf;

    logic        r_we;
    logic [18:0] r_waddr;
    logic [35:0] r_wdata;
    logic        r_done;

    logic        w_sof;
    logic        w_push;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_drop;
    logic [35:0] w_word;
    logic [18:0] w_addr_next;
    logic [54:0] w_head;

    // SOF restarts the word; a lane-3 SOF pixel therefore never pushes
    assign w_sof       = pix_valid & pix_sof;
    assign w_push      = pix_valid & ~pix_sof & (r_lane == 2'd3);
    assign w_full      = (r_level == 3'd4);
    assign w_pop       = wr_slot & (r_level != 3'd0);
    assign w_push_ok   = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    // shifting in at the LSB leaves the first pixel in the MSBs after four
    assign w_word      = {r_word[26:0], pix_data};
    assign w_addr_next = (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 19'd1;
    assign w_head      = r_mem[r_rd_ptr];

    // lane counter, partial word and next-word address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= 2'd0;
            r_word <= 36'd0;
            r_addr <= BASE_ADDR;
        end else if (w_sof) begin
            r_lane <= 2'd1;
            r_word <= {27'd0, pix_data};
            r_addr <= BASE_ADDR;
        end else if (pix_valid) begin
            r_lane <= r_lane + 2'd1;
            r_word <= w_word;
            if (r_lane == 2'd3) begin
                r_addr <= w_addr_next;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_addr, w_word};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_level  <= 3'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            unique case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + 3'd1;
                2'b01:   r_level <= r_level - 3'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    // sticky drop flag, cleared by the next start of frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_sof) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    // issue register: popped entry drives the ZBT write port one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= 19'd0;
            r_wdata <= 36'd0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= w_pop;
            r_done <= w_pop & (w_head[54:36] == LAST_ADDR);
            if (w_pop) begin
                r_waddr <= w_head[54:36];
                r_wdata <= w_head[35:0];
            end
        end
    end

    assign zbt_we         = r_we;
    assign zbt_write_addr = r_waddr;
    assign zbt_write_data = r_wdata;
    assign fifo_level     = r_level;
    assign overflow       = r_ovf;
    assign frame_done     = r_done;

endmodule
